// File: rtl/cpu_dbg_pkg.sv
// rtl/cpu_dbg_pkg.sv - shared encodings for the CPU run/debug controller
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } run_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE       = 3'd0,
        CAUSE_HALT_REQ   = 3'd1,
        CAUSE_BREAKPOINT = 3'd2,
        CAUSE_HALT_INSTR = 3'd3,
        CAUSE_TIMEOUT    = 3'd4,
        CAUSE_STEP_DONE  = 3'd5
    } stop_cause_t;

    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/cpu_bp_match.sv
// rtl/cpu_bp_match.sv - breakpoint slot registers and PC comparator bank
module cpu_bp_match #(
    parameter int ADDR_W   = 32,
    parameter int NUM_BP   = 4,
    parameter int BP_IDX_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc,
    input  logic                we,
    input  logic [BP_IDX_W-1:0] idx,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                en,
    output logic                hit,
    output logic [BP_IDX_W-1:0] hit_idx
);

    logic [ADDR_W-1:0] slot_addr [NUM_BP];
    logic [NUM_BP-1:0] slot_en;
    logic [NUM_BP-1:0] match;

    // Slot storage; indices with no backing slot never match the loop and are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BP; i++) begin
                slot_addr[i] <= '0;
            end
            slot_en <= '0;
        end else begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (we && (idx == BP_IDX_W'(i))) begin
                    slot_addr[i] <= addr;
                    slot_en[i]   <= en;
                end
            end
        end
    end

    // Compare against the registered slots, so a write this cycle does not affect the match
    always_comb begin
        match   = '0;
        hit_idx = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            match[i] = slot_en[i] && (slot_addr[i] == pc);
        end
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_idx = BP_IDX_W'(i);
            end
        end
        hit = |match;
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/halt controller producing the CPU advance enable
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          NUM_BP     = 4,
    parameter int          BP_IDX_W   = 2,
    parameter int          CNT_W      = 32,
    parameter int          MAX_CYCLES = 500,
    parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
    input  logic                CLOCK_50,
    input  logic                Reset,
    input  logic                Run,
    input  logic                resume,
    input  logic                step,
    input  logic                halt_req,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [31:0]         instr,
    input  logic                bp_we,
    input  logic [BP_IDX_W-1:0] bp_idx,
    input  logic [ADDR_W-1:0]   bp_addr,
    input  logic                bp_en,
    output logic                cpu_en,
    output logic [1:0]          state,
    output logic                halted,
    output logic [2:0]          stop_cause,
    output logic [BP_IDX_W-1:0] bp_hit_idx,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    run_state_t          cur_state;
    stop_cause_t         cause_q;
    stop_cause_t         run_cause;
    logic                skip_bp;
    logic                bp_hit;
    logic [BP_IDX_W-1:0] bp_hit_lowest;
    logic                is_halt_instr;
    logic                timed_out;
    logic                stop_now;

    cpu_bp_match #(
        .ADDR_W   (ADDR_W),
        .NUM_BP   (NUM_BP),
        .BP_IDX_W (BP_IDX_W)
    ) u_bp_match (
        .clk     (CLOCK_50),
        .rst     (Reset),
        .pc      (pc),
        .we      (bp_we),
        .idx     (bp_idx),
        .addr    (bp_addr),
        .en      (bp_en),
        .hit     (bp_hit),
        .hit_idx (bp_hit_lowest)
    );

    assign is_halt_instr = (instr == HALT_INSTR);
    assign timed_out     = (MAX_CYCLES != 0) && (cycle_cnt >= CNT_W'(MAX_CYCLES));
    assign stop_now      = (run_cause != CAUSE_NONE);
    assign state         = cur_state;
    assign stop_cause    = cause_q;

    // Highest-priority reason to stop the instruction currently at pc while running
    always_comb begin
        run_cause = CAUSE_NONE;
        if (halt_req) begin
            run_cause = CAUSE_HALT_REQ;
        end else if (bp_hit && !skip_bp) begin
            run_cause = CAUSE_BREAKPOINT;
        end else if (is_halt_instr) begin
            run_cause = CAUSE_HALT_INSTR;
        end else if (timed_out) begin
            run_cause = CAUSE_TIMEOUT;
        end
    end

    // Same-cycle advance enable; a stopping instruction is never executed
    always_comb begin
        cpu_en = 1'b0;
        if (!Reset) begin
            case (cur_state)
                ST_RUN:  cpu_en = !stop_now;
                ST_STEP: cpu_en = !is_halt_instr;
                default: cpu_en = 1'b0;
            endcase
        end
    end

    // Saturating cycle and retired-instruction counters
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if ((cur_state == ST_RUN) && (cycle_cnt != CNT_MAX)) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (cpu_en && (instr_cnt != CNT_MAX)) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    // Run-control state machine with registered status outputs
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            cur_state  <= ST_IDLE;
            halted     <= 1'b0;
            cause_q    <= CAUSE_NONE;
            bp_hit_idx <= '0;
            skip_bp    <= 1'b0;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    if (step) begin
                        cur_state <= ST_STEP;
                    end else if (Run) begin
                        cur_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    skip_bp <= 1'b0;
                    if (stop_now) begin
                        cur_state <= ST_HALT;
                        halted    <= 1'b1;
                        cause_q   <= run_cause;
                        if (run_cause == CAUSE_BREAKPOINT) begin
                            bp_hit_idx <= bp_hit_lowest;
                        end
                    end else if (!Run) begin
                        cur_state <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    cur_state <= ST_HALT;
                    halted    <= 1'b1;
                    cause_q   <= is_halt_instr ? CAUSE_HALT_INSTR : CAUSE_STEP_DONE;
                end
                ST_HALT: begin
                    if (step) begin
                        cur_state <= ST_STEP;
                        halted    <= 1'b0;
                    end else if (resume) begin
                        cur_state <= ST_RUN;
                        halted    <= 1'b0;
                        skip_bp   <= 1'b1;
                    end else if (!Run) begin
                        cur_state <= ST_IDLE;
                        halted    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

    localparam int          ADDR_W     = 32;
    localparam int          NUM_BP     = 3;
    localparam int          BP_IDX_W   = 2;
    localparam int          CNT_W      = 32;
    localparam int          MAX_CYCLES = 500;
    localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;
    localparam longint      CNT_SAT    = (64'd1 << CNT_W) - 1;

    logic                CLOCK_50 = 1'b0;
    logic                Reset    = 1'b1;
    logic                Run      = 1'b0;
    logic                resume   = 1'b0;
    logic                step     = 1'b0;
    logic                halt_req = 1'b0;
    logic [ADDR_W-1:0]   pc       = '0;
    logic [31:0]         instr    = 32'h0000_0013;
    logic                bp_we    = 1'b0;
    logic [BP_IDX_W-1:0] bp_idx   = '0;
    logic [ADDR_W-1:0]   bp_addr  = '0;
    logic                bp_en    = 1'b0;
    logic                cpu_en;
    logic [1:0]          state;
    logic                halted;
    logic [2:0]          stop_cause;
    logic [BP_IDX_W-1:0] bp_hit_idx;
    logic [CNT_W-1:0]    cycle_cnt;
    logic [CNT_W-1:0]    instr_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 running, 2 stepping, 3 halted
    int                m_state = 0;
    int                m_cause = 0;
    int                m_bpidx = 0;
    bit                m_skip  = 0;
    longint            m_cyc   = 0;
    longint            m_ins   = 0;
    logic [ADDR_W-1:0] m_slot_addr [NUM_BP];
    bit                m_slot_en   [NUM_BP];
    logic [ADDR_W-1:0] halt_pc    = 32'hFFFF_FFF0;
    bit                auto_instr = 1;

    cpu_run_ctrl #(
        .ADDR_W     (ADDR_W),
        .NUM_BP     (NUM_BP),
        .BP_IDX_W   (BP_IDX_W),
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES),
        .HALT_INSTR (HALT_WORD)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .Reset      (Reset),
        .Run        (Run),
        .resume     (resume),
        .step       (step),
        .halt_req   (halt_req),
        .pc         (pc),
        .instr      (instr),
        .bp_we      (bp_we),
        .bp_idx     (bp_idx),
        .bp_addr    (bp_addr),
        .bp_en      (bp_en),
        .cpu_en     (cpu_en),
        .state      (state),
        .halted     (halted),
        .stop_cause (stop_cause),
        .bp_hit_idx (bp_hit_idx),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic int m_lowest_hit();
        for (int i = 0; i < NUM_BP; i++) begin
            if (m_slot_en[i] && (m_slot_addr[i] == pc)) return i;
        end
        return -1;
    endfunction

    function automatic int m_run_stop();
        int reasons[$];
        if (halt_req) reasons.push_back(1);
        if (!m_skip && (m_lowest_hit() >= 0)) reasons.push_back(2);
        if (instr == HALT_WORD) reasons.push_back(3);
        if ((MAX_CYCLES != 0) && (m_cyc >= MAX_CYCLES)) reasons.push_back(4);
        return (reasons.size() == 0) ? 0 : reasons[0];
    endfunction

    function automatic bit m_en();
        if (Reset) return 0;
        if (m_state == 1) return (m_run_stop() == 0);
        if (m_state == 2) return (instr != HALT_WORD);
        return 0;
    endfunction

    function automatic void m_advance();
        bit en   = m_en();
        int code = m_run_stop();
        int hit  = m_lowest_hit();
        int nxt  = m_state;
        if (Reset) begin
            m_state = 0; m_cause = 0; m_bpidx = 0; m_skip = 0; m_cyc = 0; m_ins = 0;
            for (int i = 0; i < NUM_BP; i++) begin
                m_slot_addr[i] = '0;
                m_slot_en[i]   = 0;
            end
            return;
        end
        if ((m_state == 1) && (m_cyc < CNT_SAT)) m_cyc++;
        if (en && (m_ins < CNT_SAT)) m_ins++;
        case (m_state)
            0: nxt = step ? 2 : (Run ? 1 : 0);
            1: begin
                m_skip = 0;
                if (code != 0) begin
                    nxt = 3;
                    m_cause = code;
                    if (code == 2) m_bpidx = hit;
                end else if (!Run) begin
                    nxt = 0;
                end
            end
            2: begin
                nxt = 3;
                m_cause = (instr == HALT_WORD) ? 3 : 5;
            end
            default: begin
                if (step) nxt = 2;
                else if (resume) begin nxt = 1; m_skip = 1; end
                else if (!Run) nxt = 0;
            end
        endcase
        m_state = nxt;
        if (bp_we && (bp_idx < NUM_BP)) begin
            m_slot_addr[bp_idx] = bp_addr;
            m_slot_en[bp_idx]   = bp_en;
        end
    endfunction

    // One clock: advance the model, the simulated CPU's pc and clear pulses
    task automatic tick();
        bit en;
        en = m_en();
        m_advance();
        @(posedge CLOCK_50);
        #1;
        if (en) pc = pc + 32'd4;
        if (auto_instr) instr = (pc == halt_pc) ? HALT_WORD : 32'h0000_0013;
        step = 0; resume = 0; halt_req = 0; bp_we = 0;
        #1;
    endtask

    task automatic do_reset();
        Reset = 1; Run = 0;
        tick();
        Reset = 0; pc = '0; halt_pc = 32'hFFFF_FFF0; auto_instr = 1; instr = 32'h0000_0013;
        #1;
    endtask

    task automatic write_bp(input int idx, input logic [ADDR_W-1:0] addr);
        bp_we = 1; bp_idx = BP_IDX_W'(idx); bp_addr = addr; bp_en = 1;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1; Run = 1;
        #1;
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL reset_cpu_en got=%b exp=0", cpu_en); end
        tick();
        Reset = 0; Run = 0; pc = '0;
        #1;
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (stop_cause !== 3'd0) begin failures++; $display("FAIL reset_cause got=%0d exp=0", stop_cause); end
        checks++; if (bp_hit_idx !== '0) begin failures++; $display("FAIL reset_bp_idx got=%0d exp=0", bp_hit_idx); end
        checks++; if ((cycle_cnt !== '0) || (instr_cnt !== '0)) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cycle_cnt, instr_cnt); end
        Run = 1;
        tick();
        checks++; if ((state !== 2'd1) || (cpu_en !== 1'b1)) begin failures++; $display("FAIL reset_slots_disabled state=%0d cpu_en=%b exp=1/1", state, cpu_en); end
    endtask

    task automatic test_timeout();
        int n_en = 0;
        do_reset();
        Run = 1;
        for (int i = 0; (i < 700) && (m_state != 3); i++) begin
            if (cpu_en === 1'b1) n_en++;
            tick();
        end
        checks++; if (n_en != 500) begin failures++; $display("FAIL timeout_en_cycles got=%0d exp=500", n_en); end
        checks++; if ((state !== 2'd3) || (halted !== 1'b1)) begin failures++; $display("FAIL timeout_state got=%0d halted=%b exp=3/1", state, halted); end
        checks++; if (stop_cause !== 3'd4) begin failures++; $display("FAIL timeout_cause got=%0d exp=4", stop_cause); end
        checks++; if (instr_cnt !== 32'd500) begin failures++; $display("FAIL timeout_instr_cnt got=%0d exp=500", instr_cnt); end
        checks++; if (cycle_cnt !== 32'd501) begin failures++; $display("FAIL timeout_cycle_cnt got=%0d exp=501", cycle_cnt); end
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL timeout_cpu_en got=%b exp=0", cpu_en); end
        resume = 1;
        tick();
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL timeout_refire_en got=%b exp=0", cpu_en); end
        tick();
        checks++; if ((state !== 2'd3) || (stop_cause !== 3'd4) || (instr_cnt !== 32'd500)) begin
            failures++; $display("FAIL timeout_refire state=%0d cause=%0d instr_cnt=%0d exp=3/4/500", state, stop_cause, instr_cnt);
        end
    endtask

    task automatic test_breakpoint_resume();
        int n_en = 0;
        do_reset();
        write_bp(2, 32'h10);
        Run = 1;
        for (int i = 0; (i < 50) && (m_state != 3); i++) begin
            if (cpu_en === 1'b1) n_en++;
            tick();
        end
        checks++; if (n_en != 4) begin failures++; $display("FAIL bp_en_cycles got=%0d exp=4", n_en); end
        checks++; if ((state !== 2'd3) || (stop_cause !== 3'd2) || (cpu_en !== 1'b0)) begin
            failures++; $display("FAIL bp_stop state=%0d cause=%0d cpu_en=%b exp=3/2/0", state, stop_cause, cpu_en);
        end
        checks++; if (bp_hit_idx !== 2'd2) begin failures++; $display("FAIL bp_hit_idx got=%0d exp=2", bp_hit_idx); end
        resume = 1;
        tick();
        checks++; if ((state !== 2'd1) || (cpu_en !== 1'b1)) begin failures++; $display("FAIL bp_resume_past state=%0d cpu_en=%b exp=1/1", state, cpu_en); end
        tick();
        checks++; if ((state !== 2'd1) || (cpu_en !== 1'b1) || (instr_cnt !== 32'd5)) begin
            failures++; $display("FAIL bp_resume_continue state=%0d cpu_en=%b instr_cnt=%0d exp=1/1/5", state, cpu_en, instr_cnt);
        end
    endtask

    task automatic test_step();
        do_reset();
        Run = 1;
        tick();
        halt_req = 1;
        tick();
        checks++; if ((state !== 2'd3) || (stop_cause !== 3'd1)) begin failures++; $display("FAIL step_setup state=%0d cause=%0d exp=3/1", state, stop_cause); end
        for (int k = 0; k < 2; k++) begin
            step = 1;
            #1;
            checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL step_halt_en pass=%0d got=%b exp=0", k, cpu_en); end
            tick();
            checks++; if ((state !== 2'd2) || (cpu_en !== 1'b1)) begin failures++; $display("FAIL step_exec pass=%0d state=%0d cpu_en=%b exp=2/1", k, state, cpu_en); end
            tick();
            checks++; if ((state !== 2'd3) || (stop_cause !== 3'd5)) begin failures++; $display("FAIL step_done pass=%0d state=%0d cause=%0d exp=3/5", k, state, stop_cause); end
        end
        checks++; if (instr_cnt !== 32'd2) begin failures++; $display("FAIL step_instr_cnt got=%0d exp=2", instr_cnt); end
    endtask

    task automatic test_halt_instr();
        int n_en = 0;
        int bad  = 0;
        do_reset();
        halt_pc = 32'h24;
        Run = 1;
        for (int i = 0; (i < 50) && (m_state != 3); i++) begin
            if (cpu_en === 1'b1) n_en++;
            if ((pc == 32'h24) && (cpu_en !== 1'b0)) bad++;
            tick();
        end
        checks++; if ((n_en != 9) || (bad != 0)) begin failures++; $display("FAIL hi_en_cycles got=%0d bad=%0d exp=9/0", n_en, bad); end
        checks++; if ((state !== 2'd3) || (stop_cause !== 3'd3)) begin failures++; $display("FAIL hi_stop state=%0d cause=%0d exp=3/3", state, stop_cause); end
        step = 1;
        tick();
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL hi_step_en got=%b exp=0", cpu_en); end
        tick();
        checks++; if ((state !== 2'd3) || (stop_cause !== 3'd3) || (instr_cnt !== 32'd9)) begin
            failures++; $display("FAIL hi_step_result state=%0d cause=%0d instr_cnt=%0d exp=3/3/9", state, stop_cause, instr_cnt);
        end
    endtask

    task automatic test_halt_req_priority();
        do_reset();
        write_bp(1, 32'h8);
        Run = 1;
        for (int i = 0; (i < 20) && !((pc == 32'h8) && (m_state == 1)); i++) tick();
        halt_req = 1;
        #1;
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL prio_en got=%b exp=0", cpu_en); end
        tick();
        checks++; if ((state !== 2'd3) || (stop_cause !== 3'd1) || (bp_hit_idx !== 2'd0)) begin
            failures++; $display("FAIL prio_cause state=%0d cause=%0d bp_hit_idx=%0d exp=3/1/0", state, stop_cause, bp_hit_idx);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_en = 0;
        do_reset();
        write_bp(0, 32'h20);
        Run = 1;
        for (int i = 0; i < 5; i++) tick();
        Reset = 1;
        #1;
        checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL midreset_en got=%b exp=0", cpu_en); end
        tick();
        Reset = 0; pc = '0;
        #1;
        checks++; if ((state !== 2'd0) || (cycle_cnt !== '0) || (instr_cnt !== '0)) begin
            failures++; $display("FAIL midreset_clear state=%0d cyc=%0d ins=%0d exp=0/0/0", state, cycle_cnt, instr_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            if (cpu_en === 1'b1) n_en++;
            tick();
        end
        checks++; if ((n_en != 19) || (state !== 2'd1)) begin failures++; $display("FAIL midreset_slot_cleared en=%0d state=%0d exp=19/1", n_en, state); end
    endtask

    task automatic test_random();
        do_reset();
        auto_instr = 0;
        for (int c = 0; c < 1500; c++) begin
            Reset    = ($urandom_range(0, 199) == 0);
            Run      = ($urandom_range(0, 9) != 0);
            step     = ($urandom_range(0, 14) == 0);
            resume   = ($urandom_range(0, 9) == 0);
            halt_req = ($urandom_range(0, 19) == 0);
            bp_we    = ($urandom_range(0, 7) == 0);
            bp_idx   = BP_IDX_W'($urandom_range(0, 3));
            bp_addr  = 32'(4 * $urandom_range(0, 15));
            bp_en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) pc = 32'(4 * $urandom_range(0, 15));
            instr    = ($urandom_range(0, 19) == 0) ? HALT_WORD : $urandom;
            #1;
            checks++; if (cpu_en !== m_en()) begin failures++; $display("FAIL rnd_cpu_en cyc=%0d got=%b exp=%b", c, cpu_en, m_en()); end
            tick();
            checks++; if (state !== 2'(m_state)) begin failures++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", c, state, m_state); end
            checks++; if (halted !== (m_state == 3)) begin failures++; $display("FAIL rnd_halted cyc=%0d got=%b exp=%b", c, halted, m_state == 3); end
            checks++; if (stop_cause !== 3'(m_cause)) begin failures++; $display("FAIL rnd_cause cyc=%0d got=%0d exp=%0d", c, stop_cause, m_cause); end
            checks++; if (bp_hit_idx !== BP_IDX_W'(m_bpidx)) begin failures++; $display("FAIL rnd_bp_idx cyc=%0d got=%0d exp=%0d", c, bp_hit_idx, m_bpidx); end
            checks++; if (cycle_cnt !== CNT_W'(m_cyc)) begin failures++; $display("FAIL rnd_cycle_cnt cyc=%0d got=%0d exp=%0d", c, cycle_cnt, m_cyc); end
            checks++; if (instr_cnt !== CNT_W'(m_ins)) begin failures++; $display("FAIL rnd_instr_cnt cyc=%0d got=%0d exp=%0d", c, instr_cnt, m_ins); end
        end
        auto_instr = 1;
    endtask

    initial begin
        for (int i = 0; i < NUM_BP; i++) begin
            m_slot_addr[i] = '0;
            m_slot_en[i]   = 0;
        end
        test_reset();
        test_timeout();
        test_breakpoint_resume();
        test_step();
        test_halt_instr();
        test_halt_req_priority();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/debug controller for the single-cycle CPU. It generates the per-cycle advance enable that gates PC, register-file and memory writes. It supports free run, single-step, external halt, NUM_BP PC breakpoints, a halt-opcode stop and a cycle-budget timeout. Cycle and retired-instruction counters feed bench and board visibility.

Parameters:
ADDR_W, 32, PC/breakpoint address width
NUM_BP, 4, number of breakpoint comparators (1..16)
BP_IDX_W, 2, width of breakpoint index (>= clog2(NUM_BP), min 1)
CNT_W, 32, width of cycle/instruction counters
MAX_CYCLES, 500, RUN-cycle budget before timeout stop; 0 = timeout disabled
HALT_INSTR, 32'hFFFF_FFFF, instruction word that stops execution

Ports:
CLOCK_50  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Run  in  1  level; enables free run from IDLE
resume  in  1  pulse; continue RUN from HALT
step  in  1  pulse; execute exactly one instruction from IDLE/HALT
halt_req  in  1  pulse; stop before next instruction
pc  in  ADDR_W  current PC (pc_out of CPU)
instr  in  32  instruction at pc
bp_we  in  1  write breakpoint slot
bp_idx  in  BP_IDX_W  slot index
bp_addr  in  ADDR_W  breakpoint PC
bp_en  in  1  slot enable written with bp_addr
cpu_en  out  1  CPU advance enable (combinational)
state  out  2  IDLE=0, RUN=1, STEP=2, HALT=3
halted  out  1  registered, 1 in HALT
stop_cause  out  3  0 none, 1 halt_req, 2 breakpoint, 3 halt_instr, 4 timeout, 5 step_done
bp_hit_idx  out  BP_IDX_W  lowest matching slot at last breakpoint stop
cycle_cnt  out  CNT_W  cycles spent in RUN, saturating
instr_cnt  out  CNT_W  cycles with cpu_en=1, saturating

Behaviour:
- Reset (sync): state=IDLE, all slots disabled (addr 0), skip_bp=0, halted=0, stop_cause=0, bp_hit_idx=0, counters=0. Reset mid-run takes effect at that edge; cpu_en=0 while Reset=1.
- cpu_en = (state==RUN && !stop_now) || (state==STEP && instr!=HALT_INSTR). Zero latency: same-cycle gating of the instruction at pc.
- stop_now, in RUN, priority high->low:
  - halt_req
  - bp match: any enabled slot with addr==pc, masked when skip_bp=1
  - instr==HALT_INSTR
  - MAX_CYCLES!=0 && cycle_cnt>=MAX_CYCLES
- IDLE: step -> STEP; else Run -> RUN; else stay. cpu_en=0.
- RUN:
  - Any stop_now: -> HALT, stop_cause=code of highest-priority condition, bp_hit_idx updated only for breakpoint stops. Stopping instruction not executed.
  - Else if Run=0: -> IDLE, stop_cause unchanged.
  - cycle_cnt increments every RUN cycle.
- STEP: one cycle only. If instr==HALT_INSTR -> HALT with cause 3; else -> HALT with cause 5. Breakpoints and timeout ignored in STEP.
- HALT: cpu_en=0; priority step > resume.
  - step -> STEP.
  - resume -> RUN with skip_bp=1.
  - Run=0 with neither pulse -> IDLE.
- skip_bp clears after the first RUN cycle. This lets the resumed instruction execute past its own breakpoint.
- Pulses asserted in a state where they have no meaning are ignored.
- bp_we is honoured in every state. A match in the write cycle uses the old slot contents.
- bp_idx >= NUM_BP: write ignored.
- Counters saturate at all-ones and never wrap. Timeout re-fires immediately on resume once budget is exhausted; only Reset clears cycle_cnt.

Decomposition:
- Package cpu_dbg_pkg: state encodings, stop_cause codes, default HALT_INSTR.
- Sub-module cpu_bp_match: NUM_BP slot registers + comparator bank. Outputs hit and lowest hit index.
- FSM, counters and cpu_en logic live in cpu_run_ctrl.

Test Plan:
- Reset, Run=1, pc increments by 4, no slots: 500 cycles with cpu_en=1. At cycle_cnt=500: state=HALT, stop_cause=4, instr_cnt=500, cpu_en=0.
- Slot 2 = 0x0000_0010 enabled, Run=1: halt when pc=0x10 with cpu_en=0, stop_cause=2, bp_hit_idx=2. Pulse resume: cpu_en=1 at pc=0x10, then run continues.
- From HALT, pulse step twice: exactly one cpu_en=1 cycle per pulse, instr_cnt +2, stop_cause=5 each time.
- instr=32'hFFFF_FFFF at pc=0x24 during RUN: HALT with stop_cause=3, no cpu_en at 0x24. Step there: stays HALT, cause 3, instr_cnt unchanged.
- halt_req and breakpoint in the same cycle: stop_cause=1, bp_hit_idx unchanged.
- Reset asserted mid-RUN: next cycle state=IDLE, counters=0, all slots disabled (bp at old address no longer hits).
